mem_access_master: RTL and testbench

- Initiator side of the data-memory interface: accepts single-word load/store requests from the CPU datapath and drives the address, write-data and r_flag/w_flag strobes into the Memory block.
- Captures returned read data and hands it back with a valid/ready response handshake.
- Range-checks addresses against the memory depth, so out-of-range accesses never reach the array.

---
 rtl/mem_if_pkg.sv | 22 ++
 rtl/mem_access_master.sv | 167 ++++++++++++++++
 tb/tb_mem_access_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared types and default sizes for the data-memory interface.
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    // Access-master sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DEPTH  = 16;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Purpose  : CPU-side initiator for the data memory. Takes one load/store at
//            a time, drives registered address/data/strobes into the Memory,
//            range-checks addresses and returns a valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master
    import mem_if_pkg::*;
#(
    parameter int DATA_W       = MEM_DATA_W,
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DEPTH        = MEM_DEPTH,
    parameter int READ_LATENCY = 1            // legal range 1..4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic        [ADDR_W-1:0] req_addr,
    input  logic signed [DATA_W-1:0] req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic signed [DATA_W-1:0] resp_rdata,
    output logic                     resp_err,
    output logic        [ADDR_W-1:0] mem_address,
    output logic signed [DATA_W-1:0] mem_write_data,
    output logic                     mem_r_flag,
    output logic                     mem_w_flag,
    input  logic signed [DATA_W-1:0] mem_read_data
);

    // Unsigned bound for the range check and terminal count of the read wait
    localparam logic [ADDR_W-1:0] c_DEPTH    = ADDR_W'(DEPTH);
    localparam logic [1:0]        c_LAT_LAST = 2'(READ_LATENCY - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [1:0]                 r_cnt;
    logic [1:0]                 w_cnt_nxt;
    logic                       r_resp_valid;
    logic                       w_resp_valid_nxt;
    logic                       r_resp_err;
    logic                       w_resp_err_nxt;
    logic signed [DATA_W-1:0]   r_resp_rdata;
    logic signed [DATA_W-1:0]   w_resp_rdata_nxt;
    logic        [ADDR_W-1:0]   r_mem_address;
    logic        [ADDR_W-1:0]   w_mem_address_nxt;
    logic signed [DATA_W-1:0]   r_mem_write_data;
    logic signed [DATA_W-1:0]   w_mem_write_data_nxt;
    logic                       r_mem_r_flag;
    logic                       w_mem_r_flag_nxt;
    logic                       r_mem_w_flag;
    logic                       w_mem_w_flag_nxt;
    logic                       w_accept;

    // Ready only in IDLE and forced low while reset is held, so it rises the
    // moment reset is released without waiting for a clock edge.
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign resp_rdata     = r_resp_rdata;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign mem_r_flag     = r_mem_r_flag;
    assign mem_w_flag     = r_mem_w_flag;

    // Next-state and next-output decode; strobes default low every cycle
    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_resp_valid_nxt     = r_resp_valid;
        w_resp_err_nxt       = r_resp_err;
        w_resp_rdata_nxt     = r_resp_rdata;
        w_mem_address_nxt    = r_mem_address;
        w_mem_write_data_nxt = r_mem_write_data;
        w_mem_r_flag_nxt     = 1'b0;
        w_mem_w_flag_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_addr >= c_DEPTH) begin
                        // Out of range: answer directly, never touch memory
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_rdata_nxt = '0;
                    end else begin
                        w_mem_address_nxt = req_addr;
                        if (req_write) begin
                            w_state_nxt          = WRITE;
                            w_mem_write_data_nxt = req_wdata;
                            w_mem_w_flag_nxt     = 1'b1;
                        end else begin
                            w_state_nxt      = READ;
                            w_mem_r_flag_nxt = 1'b1;
                            w_cnt_nxt        = 2'd0;
                        end
                    end
                end
            end

            WRITE: begin
                w_state_nxt      = RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_err_nxt   = 1'b0;
                w_resp_rdata_nxt = '0;
            end

            READ: begin
                if (r_cnt == c_LAT_LAST) begin
                    // Last cycle of the strobe: capture the memory output
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_rdata_nxt = mem_read_data;
                end else begin
                    w_cnt_nxt        = r_cnt + 2'd1;
                    w_mem_r_flag_nxt = 1'b1;
                end
            end

            RESP: begin
                if (resp_ready) begin
                    w_state_nxt      = IDLE;
                    w_resp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset clears everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_cnt            <= 2'd0;
            r_resp_valid     <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= '0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_mem_r_flag     <= 1'b0;
            r_mem_w_flag     <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_resp_valid     <= w_resp_valid_nxt;
            r_resp_err       <= w_resp_err_nxt;
            r_resp_rdata     <= w_resp_rdata_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_write_data <= w_mem_write_data_nxt;
            r_mem_r_flag     <= w_mem_r_flag_nxt;
            r_mem_w_flag     <= w_mem_w_flag_nxt;
        end
    end

endmodule : mem_access_master
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_master
// Purpose  : Self-checking bench for mem_access_master: directed cases plus
//            random load/store traffic against a word-level memory model.
//            A second instance built with READ_LATENCY=2 checks the longer
//            read strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_master;

    localparam int c_DEPTH = 16;
    localparam int c_LAT   = 1;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;
    logic [15:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_r_flag, mem_w_flag;

    logic        l2_req_valid, l2_req_ready;
    logic        l2_resp_valid, l2_resp_ready, l2_resp_err;
    logic [15:0] l2_resp_rdata, l2_mem_address, l2_mem_write_data, l2_read_data;
    logic        l2_r_flag, l2_w_flag;
    logic [1:0]  l2_rcyc;

    logic [15:0] mem_arr   [c_DEPTH];
    logic [15:0] model_mem [c_DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_master #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(c_DEPTH), .READ_LATENCY(c_LAT)
    ) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_r_flag(mem_r_flag), .mem_w_flag(mem_w_flag),
        .mem_read_data(mem_read_data)
    );

    mem_access_master #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(c_DEPTH), .READ_LATENCY(2)
    ) u_dut_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(l2_req_valid), .req_ready(l2_req_ready), .req_write(1'b0),
        .req_addr(16'd5), .req_wdata(16'd0),
        .resp_valid(l2_resp_valid), .resp_ready(l2_resp_ready),
        .resp_rdata(l2_resp_rdata), .resp_err(l2_resp_err),
        .mem_address(l2_mem_address), .mem_write_data(l2_mem_write_data),
        .mem_r_flag(l2_r_flag), .mem_w_flag(l2_w_flag),
        .mem_read_data(l2_read_data)
    );

    // Attached memory for the main instance: write on w_flag, combinational read
    always @(posedge clk) begin
        if (mem_w_flag && mem_address < c_DEPTH)
            mem_arr[mem_address[3:0]] <= mem_write_data;
    end
    assign mem_read_data = (mem_r_flag && mem_address < c_DEPTH) ? mem_arr[mem_address[3:0]] : 16'h0000;

    // Latency-2 memory: valid data only in the second strobe cycle
    always @(posedge clk or posedge reset) begin
        if (reset)          l2_rcyc <= 2'd0;
        else if (l2_r_flag) l2_rcyc <= l2_rcyc + 2'd1;
        else                l2_rcyc <= 2'd0;
    end
    assign l2_read_data = (l2_r_flag && l2_rcyc == 2'd1) ? 16'h7FFF : 16'h0BAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete transaction; starts and ends just after a falling edge
    task automatic run_txn(input logic wr, input logic [15:0] addr,
                           input logic [15:0] wd, input int hold);
        logic        err_exp;
        logic [15:0] rd_exp;
        int          lat_exp, rcnt_exp, wcnt_exp;
        int          rcnt, wcnt, lat;
        bit          seen;
        err_exp  = (addr >= c_DEPTH);
        rd_exp   = 16'h0000;
        lat_exp  = err_exp ? 1 : (wr ? 2 : 1 + c_LAT);
        rcnt_exp = (!err_exp && !wr) ? c_LAT : 0;
        wcnt_exp = (!err_exp && wr) ? 1 : 0;
        if (!err_exp && !wr) rd_exp = model_mem[addr[3:0]];
        if (!err_exp && wr)  model_mem[addr[3:0]] = wd;

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;   // must not matter once registered
        req_wdata = $urandom;

        rcnt = 0; wcnt = 0; lat = 0; seen = 0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_r_flag && mem_w_flag) check("both_flags", 32'd1, 32'd0);
            if (mem_r_flag) begin
                rcnt++;
                check("rd_addr", {16'd0, mem_address}, {16'd0, addr});
            end
            if (mem_w_flag) begin
                wcnt++;
                check("wr_addr", {16'd0, mem_address}, {16'd0, addr});
                check("wr_data", {16'd0, mem_write_data}, {16'd0, wd});
            end
            if (resp_valid) begin
                seen = 1;
                lat  = c;
                break;
            end
            @(negedge clk);
        end
        check("resp_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, lat_exp);
        check("r_flag_cycles", rcnt, rcnt_exp);
        check("w_flag_cycles", wcnt, wcnt_exp);
        check("resp_rdata", {16'd0, resp_rdata}, {16'd0, rd_exp});
        check("resp_err", {31'd0, resp_err}, {31'd0, err_exp});
        check("req_ready_resp", {31'd0, req_ready}, 32'd0);

        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;    // ignored outside IDLE
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", {16'd0, resp_rdata}, {16'd0, rd_exp});
            check("hold_err", {31'd0, resp_err}, {31'd0, err_exp});
            check("hold_ready", {31'd0, req_ready}, 32'd0);
            check("hold_flags", {30'd0, mem_r_flag, mem_w_flag}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("post_hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        int          r, l2_cnt, l2_lat;
        bit          l2_seen;

        for (int i = 0; i < c_DEPTH; i++) begin
            mem_arr[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; l2_req_valid = 1'b0; l2_resp_ready = 1'b0;

        // Reset state while reset is held
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_flags", {30'd0, mem_r_flag, mem_w_flag}, 32'd0);
        check("rst_rdata_err", {15'd0, resp_err, resp_rdata}, 32'd0);
        check("rst_addr_data", {mem_address, mem_write_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Store then load, signed data, out of range, backpressure
        run_txn(1'b1, 16'd3, 16'h1234, 0);
        run_txn(1'b0, 16'd3, 16'h0000, 0);
        run_txn(1'b1, 16'd15, 16'hFFFB, 0);
        run_txn(1'b0, 16'd15, 16'h0000, 1);
        run_txn(1'b0, 16'd16, 16'h0000, 0);
        run_txn(1'b1, 16'hFFFF, 16'h5555, 0);
        run_txn(1'b1, 16'd7, 16'h00AA, 0);
        run_txn(1'b0, 16'd7, 16'h0000, 3);

        // Reset in the middle of a read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rd_flag", {31'd0, mem_r_flag}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_drops_rflag", {31'd0, mem_r_flag}, 32'd0);
        check("rst_drops_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resp_after", {31'd0, resp_valid}, 32'd0);
        end

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 16'hFFFF;
            else if (r == 1) a = 16'($urandom_range(16, 300));
            else             a = 16'($urandom_range(0, 15));
            run_txn(1'($urandom_range(0, 1)), a, 16'($urandom), int'($urandom_range(0, 2)));
        end

        // READ_LATENCY=2 instance
        l2_req_valid = 1'b1;
        check("l2_ready", {31'd0, l2_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        l2_req_valid = 1'b0;
        l2_cnt = 0; l2_lat = 0; l2_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            if (l2_r_flag) l2_cnt++;
            if (l2_resp_valid) begin
                l2_seen = 1;
                l2_lat  = c;
                break;
            end
            @(negedge clk);
        end
        check("l2_seen", {31'd0, l2_seen}, 32'd1);
        check("l2_rflag_cycles", l2_cnt, 32'd2);
        check("l2_latency", l2_lat, 32'd3);
        check("l2_rdata", {16'd0, l2_resp_rdata}, 32'h7FFF);
        check("l2_err", {31'd0, l2_resp_err}, 32'd0);
        l2_resp_ready = 1'b1;
        @(negedge clk);
        l2_resp_ready = 1'b0;
        check("l2_post_hs", {30'd0, l2_resp_valid, l2_req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_access_master
`default_nettype wire
